// File: rtl/traffic_conflict_monitor.sv
// traffic_conflict_monitor
//
// Independent safety monitor for a pair of traffic-light buses. It samples the
// north-south and east-west lights every clock and checks them for:
//   1 conflicting non-red aspects, 2 illegal encodings,
//   3/4 illegal colour changes, 5 short yellow, 6 stuck green.
// The first fault found is latched, and flash mode is requested until the fault
// is cleared.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   NS_light     north-south light (00 red, 01 yellow, 10 green, 11 illegal)
//   EW_light     east-west light, same encoding
//   clear_fault  single-cycle request to leave FAULT
//   fault        high while in FAULT (registered)
//   fault_code   latched fault code, 0 when no fault is latched
//   flash_req    all-red flash request, equal to fault (registered)
//   fault_cnt    number of FAULT entries since reset, saturating at 255

module traffic_conflict_monitor #(
  parameter int unsigned YEL_MIN = 2,
  parameter int unsigned GRN_MAX = 64,
  parameter int unsigned CNT_W   = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] NS_light,
  input  logic [1:0] EW_light,
  input  logic       clear_fault,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic       flash_req,
  output logic [7:0] fault_cnt
);

  localparam logic [1:0] Red = 2'b00;
  localparam logic [1:0] Yel = 2'b01;
  localparam logic [1:0] Grn = 2'b10;
  localparam logic [1:0] Bad = 2'b11;

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
  localparam logic [CNT_W-1:0] CntSat = CNT_W'(GRN_MAX + 1);
  localparam logic [CNT_W-1:0] YelMin = CNT_W'(YEL_MIN);
  localparam logic [CNT_W-1:0] GrnMax = CNT_W'(GRN_MAX);

  typedef enum logic [1:0] {StArm, StMonitor, StFault} state_e;

  state_e           state;
  logic [1:0]       prev_ns, prev_ew;
  logic [CNT_W-1:0] cnt_ns, cnt_ew;

  // Only hold, G->Y, Y->R and R->G are legal; transitions involving 11 are
  // left to the invalid-encoding check.
  function automatic logic seq_bad(input logic [1:0] prev, input logic [1:0] cur);
    return ((prev == Grn) && (cur == Red)) ||
           ((prev == Yel) && (cur == Grn)) ||
           ((prev == Red) && (cur == Yel));
  endfunction

  // Dwell counter: restart at 1 on a colour change, otherwise count up and
  // saturate one past the green limit.
  function automatic logic [CNT_W-1:0] dwell_next(input logic load,
                                                  input logic [CNT_W-1:0] cnt);
    if (load) begin
      return CntOne;
    end else if (cnt >= CntSat) begin
      return CntSat;
    end else begin
      return cnt + CntOne;
    end
  endfunction

  logic ns_on, ew_on;
  logic hit_conflict, hit_invalid, hit_seq_ns, hit_seq_ew, hit_yel_short, hit_grn_stuck;
  logic [2:0] arm_code, mon_code;
  logic       arm_phase;

  always_comb begin
    ns_on        = (NS_light == Yel) || (NS_light == Grn);
    ew_on        = (EW_light == Yel) || (EW_light == Grn);
    hit_conflict = ns_on && ew_on;
    hit_invalid  = (NS_light == Bad) || (EW_light == Bad);
    hit_seq_ns   = seq_bad(prev_ns, NS_light);
    hit_seq_ew   = seq_bad(prev_ew, EW_light);
    // The registered count is the dwell of the previous colour up to the
    // previous sample, i.e. the length of the yellow that is ending now.
    hit_yel_short = ((prev_ns == Yel) && (NS_light == Red) && (cnt_ns < YelMin)) ||
                    ((prev_ew == Yel) && (EW_light == Red) && (cnt_ew < YelMin));
    hit_grn_stuck = ((prev_ns == Grn) && (NS_light == Grn) && (cnt_ns >= GrnMax)) ||
                    ((prev_ew == Grn) && (EW_light == Grn) && (cnt_ew >= GrnMax));

    arm_code = 3'd0;
    if (hit_conflict) begin
      arm_code = 3'd1;
    end else if (hit_invalid) begin
      arm_code = 3'd2;
    end

    mon_code = arm_code;
    if (arm_code == 3'd0) begin
      if (hit_seq_ns) begin
        mon_code = 3'd3;
      end else if (hit_seq_ew) begin
        mon_code = 3'd4;
      end else if (hit_yel_short) begin
        mon_code = 3'd5;
      end else if (hit_grn_stuck) begin
        mon_code = 3'd6;
      end
    end

    arm_phase = (state == StArm);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= StArm;
      prev_ns    <= Red;
      prev_ew    <= Red;
      cnt_ns     <= '0;
      cnt_ew     <= '0;
      fault      <= 1'b0;
      flash_req  <= 1'b0;
      fault_code <= 3'd0;
      fault_cnt  <= 8'd0;
    end else begin
      prev_ns <= NS_light;
      prev_ew <= EW_light;
      // prev_* are stale during ARM, so every counter restarts there.
      cnt_ns  <= dwell_next(arm_phase || (NS_light != prev_ns), cnt_ns);
      cnt_ew  <= dwell_next(arm_phase || (EW_light != prev_ew), cnt_ew);

      unique case (state)
        StArm, StMonitor: begin
          logic [2:0] code;
          code = arm_phase ? arm_code : mon_code;
          if (code != 3'd0) begin
            state      <= StFault;
            fault      <= 1'b1;
            flash_req  <= 1'b1;
            fault_code <= code;
            if (fault_cnt != 8'hFF) begin
              fault_cnt <= fault_cnt + 8'd1;
            end
          end else begin
            state <= StMonitor;
          end
        end
        StFault: begin
          // Leaving FAULT requires the dangerous conditions to be gone now.
          if (clear_fault && (arm_code == 3'd0)) begin
            state      <= StArm;
            fault      <= 1'b0;
            flash_req  <= 1'b0;
            fault_code <= 3'd0;
          end
        end
        default: begin
          state <= StArm;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Directed bench for traffic_conflict_monitor with default parameters
// (YEL_MIN=2, GRN_MAX=64).

module tb_traffic_conflict_monitor;

  localparam logic [1:0] R = 2'b00;
  localparam logic [1:0] Y = 2'b01;
  localparam logic [1:0] G = 2'b10;
  localparam logic [1:0] X = 2'b11;

  logic       clk;
  logic       rst;
  logic [1:0] ns_light;
  logic [1:0] ew_light;
  logic       clear_fault;
  logic       fault;
  logic [2:0] fault_code;
  logic       flash_req;
  logic [7:0] fault_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  traffic_conflict_monitor dut (
    .clk        (clk),
    .rst        (rst),
    .NS_light   (ns_light),
    .EW_light   (ew_light),
    .clear_fault(clear_fault),
    .fault      (fault),
    .fault_code (fault_code),
    .flash_req  (flash_req),
    .fault_cnt  (fault_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Apply one sample, let it be taken on the next rising edge, settle 1ns.
  task automatic step(input logic [1:0] ns, input logic [1:0] ew, input logic clr);
    ns_light    = ns;
    ew_light    = ew;
    clear_fault = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input logic f, input logic [2:0] code,
                             input logic [7:0] cnt);
    check({tag, "_fault"}, 32'(fault), 32'(f));
    check({tag, "_flash"}, 32'(flash_req), 32'(f));
    check({tag, "_code"}, 32'(fault_code), 32'(code));
    check({tag, "_cnt"}, 32'(fault_cnt), 32'(cnt));
  endtask

  initial begin
    rst         = 1'b0;
    ns_light    = R;
    ew_light    = R;
    clear_fault = 1'b0;
    #12;
    check_state("reset", 1'b0, 3'd0, 8'd0);
    #10 rst = 1'b1;  // release at t=22, first edge at t=25 is the ARM sample

    // Legal cycle, three passes; short-yellow-OK (Y x2) is covered here too.
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 16; i++) step(G, R, 1'b0);
      for (int i = 0; i < 2; i++) step(Y, R, 1'b0);
      step(R, R, 1'b0);
      for (int i = 0; i < 6; i++) step(R, G, 1'b0);
      for (int i = 0; i < 2; i++) step(R, Y, 1'b0);
      step(R, R, 1'b0);
      check("legal_pass_fault", 32'(fault), 32'd0);
    end
    check_state("legal", 1'b0, 3'd0, 8'd0);

    // Green for exactly GRN_MAX samples, then yellow: no fault.
    // clear_fault outside FAULT must be ignored.
    for (int i = 0; i < 64; i++) step(G, R, (i == 10));
    check("grn64_fault", 32'(fault), 32'd0);
    step(Y, R, 1'b0);
    step(Y, R, 1'b0);
    step(R, R, 1'b0);
    check("grn64_then_y", 32'(fault), 32'd0);

    // Conflict, then a sequence violation that must not replace the code.
    step(G, R, 1'b0);
    check("pre_conflict", 32'(fault), 32'd0);
    step(G, Y, 1'b0);
    check_state("conflict", 1'b1, 3'd1, 8'd1);
    step(R, R, 1'b0);
    check_state("conflict_then_seq", 1'b1, 3'd1, 8'd1);

    // Clear refused while an illegal encoding is present.
    step(R, X, 1'b1);
    check_state("clear_blocked", 1'b1, 3'd1, 8'd1);
    step(R, R, 1'b1);
    check_state("clear_ok", 1'b0, 3'd0, 8'd1);
    step(R, R, 1'b0);  // ARM sample

    // NS green straight to red.
    step(G, R, 1'b0);
    step(R, R, 1'b0);
    check_state("seq_ns", 1'b1, 3'd3, 8'd2);
    step(R, R, 1'b1);
    step(R, R, 1'b0);  // ARM sample

    // EW red straight to yellow.
    step(R, Y, 1'b0);
    check_state("seq_ew", 1'b1, 3'd4, 8'd3);
    step(R, R, 1'b1);
    step(R, R, 1'b0);

    // Single-sample yellow.
    step(G, R, 1'b0);
    step(Y, R, 1'b0);
    check("y1_pre", 32'(fault), 32'd0);
    step(R, R, 1'b0);
    check_state("yel_short", 1'b1, 3'd5, 8'd4);
    step(R, R, 1'b1);
    step(R, R, 1'b0);

    // Stuck green: fires on sample GRN_MAX+1.
    for (int i = 0; i < 64; i++) step(G, R, 1'b0);
    check("grn_stuck_pre", 32'(fault), 32'd0);
    step(G, R, 1'b0);
    check_state("grn_stuck", 1'b1, 3'd6, 8'd5);

    // ARM suppresses sequence checks: G->R on the ARM sample is ignored.
    step(G, R, 1'b1);
    check("clear_from_stuck", 32'(fault), 32'd0);
    step(R, R, 1'b0);
    check("arm_seq_suppressed", 32'(fault), 32'd0);
    step(R, R, 1'b0);
    check("monitor_after_arm", 32'(fault), 32'd0);

    // ARM still catches a conflict.
    step(R, R, 1'b1);  // clear_fault in MONITOR, ignored
    check("clear_outside_fault", 32'(fault), 32'd0);
    step(Y, G, 1'b0);
    check_state("monitor_conflict2", 1'b1, 3'd1, 8'd6);
    step(R, R, 1'b1);
    step(Y, G, 1'b0);  // ARM sample with conflict
    check_state("arm_conflict", 1'b1, 3'd1, 8'd7);

    // Invalid encoding during MONITOR.
    step(R, R, 1'b1);
    step(R, R, 1'b0);
    step(X, R, 1'b0);
    check_state("invalid", 1'b1, 3'd2, 8'd8);

    // Asynchronous reset while in FAULT.
    #3 rst = 1'b0;
    #1;
    check_state("async_rst", 1'b0, 3'd0, 8'd0);
    #10 rst = 1'b1;
    step(R, R, 1'b0);
    step(R, R, 1'b0);
    check_state("after_rst", 1'b0, 3'd0, 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
